// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush, memory-wait hold with a sticky watchdog.
// Define HAZARD_PERF_EN to add the stall_cycles / flush_events performance counters.
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [4:0]  rs1_idex,
  input  logic [4:0]  rs2_idex,
  input  logic [4:0]  rd_idex,
  input  logic        memread_idex,
  input  logic [4:0]  rd_exmem,
  input  logic        regwrite_exmem,
  input  logic [4:0]  rd_memwb,
  input  logic        regwrite_memwb,
  input  logic        branch_taken_ex,
  input  logic        jump_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_hold,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
`ifdef HAZARD_PERF_EN
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
`endif
  output logic [1:0]  ctrl_state,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    RSVD     = 2'b11
  } state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);

  state_t      state, next_state;
  logic [15:0] wait_cnt;
  logic        lu, redir, mw;

  assign lu    = memread_idex && (rd_idex != 5'd0) &&
                 ((rd_idex == rs1_id) || (rd_idex == rs2_id));
  assign redir = branch_taken_ex || jump_ex;
  assign mw    = dmem_req && !dmem_ready;
  assign ctrl_state = state;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] xm_rd,
    input logic       xm_we,
    input logic [4:0] mw_rd,
    input logic       mw_we
  );
    if (xm_we && (xm_rd != 5'd0) && (xm_rd == rs))
      return 2'b10;
    else if (mw_we && (mw_rd != 5'd0) && (mw_rd == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Encoding 11 falls through the same path as RUN; only LU_STALL masks the load-use term.
  always_comb begin
    next_state = RUN;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    exmem_hold = 1'b0;
    if (mw) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      next_state = MEM_WAIT;
    end else if (redir) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (lu && (state != LU_STALL)) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      next_state = LU_STALL;
    end
    if (!rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_hold = 1'b0;
    end
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      fwd_a = fwd_sel(rs1_idex, rd_exmem, regwrite_exmem, rd_memwb, regwrite_memwb);
      fwd_b = fwd_sel(rs2_idex, rd_exmem, regwrite_exmem, rd_memwb, regwrite_memwb);
    end
  end

  // The watchdog only counts cycles that stay in MEM_WAIT; leaving clears the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == MEM_WAIT) && (next_state == MEM_WAIT)) begin
        if (wait_cnt != TIMEOUT_L) begin
          wait_cnt <= wait_cnt + 16'd1;
          if ((wait_cnt + 16'd1) == TIMEOUT_L)
            mem_timeout <= 1'b1;
        end
      end else begin
        wait_cnt <= 16'd0;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if (!pc_write && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      if (redir && !mw && (flush_events != 16'hFFFF))
        flush_events <= flush_events + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed multi-cycle sequences
// and randomized traffic compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_id, rs2_id, rs1_idex, rs2_idex, rd_idex, rd_exmem, rd_memwb;
  logic       memread_idex, regwrite_exmem, regwrite_memwb;
  logic       branch_taken_ex, jump_ex, dmem_req, dmem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, mem_timeout;
  logic [1:0] fwd_a, fwd_b, ctrl_state;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [4:0] rs1_id, rs2_id, rd_idex, rs1_idex, rs2_idex, rd_exmem, rd_memwb;
    logic       memread, rw_exmem, rw_memwb, br, jmp, req, rdy;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [11:0] exp;
  } vec_t;

  // Reference model state: which stall situation the pipeline is in, not an FSM encoding.
  bit m_waiting, m_masked, m_timeout;
  int m_waited;

  pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rs1_idex(rs1_idex), .rs2_idex(rs2_idex),
    .rd_idex(rd_idex), .memread_idex(memread_idex),
    .rd_exmem(rd_exmem), .regwrite_exmem(regwrite_exmem),
    .rd_memwb(rd_memwb), .regwrite_memwb(regwrite_memwb),
    .branch_taken_ex(branch_taken_ex), .jump_ex(jump_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_hold(exmem_hold), .fwd_a(fwd_a), .fwd_b(fwd_b),
`ifdef HAZARD_PERF_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .ctrl_state(ctrl_state), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic stim_t st(input int i1, i2, ld_rd, ld, e1, e2,
                               xm_rd, xm_w, wb_rd, wb_w, br, jp, rq, rdy);
    stim_t s;
    s.rs1_id = 5'(i1);   s.rs2_id = 5'(i2);
    s.rd_idex = 5'(ld_rd); s.memread = 1'(ld);
    s.rs1_idex = 5'(e1); s.rs2_idex = 5'(e2);
    s.rd_exmem = 5'(xm_rd); s.rw_exmem = 1'(xm_w);
    s.rd_memwb = 5'(wb_rd); s.rw_memwb = 1'(wb_w);
    s.br = 1'(br); s.jmp = 1'(jp); s.req = 1'(rq); s.rdy = 1'(rdy);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rs1_id = 5'($urandom_range(3, 0));   s.rs2_id = 5'($urandom_range(3, 0));
    s.rd_idex = 5'($urandom_range(3, 0));  s.memread = 1'($urandom_range(1, 0));
    s.rs1_idex = 5'($urandom_range(3, 0)); s.rs2_idex = 5'($urandom_range(3, 0));
    s.rd_exmem = 5'($urandom_range(3, 0)); s.rw_exmem = 1'($urandom_range(1, 0));
    s.rd_memwb = 5'($urandom_range(3, 0)); s.rw_memwb = 1'($urandom_range(1, 0));
    s.br = ($urandom_range(7, 0) == 0);    s.jmp = ($urandom_range(7, 0) == 0);
    s.req = ($urandom_range(2, 0) == 0);   s.rdy = 1'($urandom_range(1, 0));
    return s;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
    if (s.rw_exmem && s.rd_exmem != 0 && s.rd_exmem == rs) return 2'b10;
    if (s.rw_memwb && s.rd_memwb != 0 && s.rd_memwb == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, fwd_a, fwd_b, ctrl_state, mem_timeout}.
  function automatic logic [11:0] model_out(input stim_t s);
    logic [4:0] ctl;
    logic [1:0] cs;
    bit lu;
    if (!rst) return 12'b00110_00_00_00_0;
    lu = s.memread && s.rd_idex != 0 && (s.rd_idex == s.rs1_id || s.rd_idex == s.rs2_id) && !m_masked;
    cs = m_waiting ? 2'b10 : (m_masked ? 2'b01 : 2'b00);
    if (s.req && !s.rdy)      ctl = 5'b00001;
    else if (s.br || s.jmp)   ctl = 5'b11110;
    else if (lu)              ctl = 5'b00010;
    else                      ctl = 5'b11000;
    return {ctl, ref_fwd(s.rs1_idex, s), ref_fwd(s.rs2_idex, s), cs, m_timeout};
  endfunction

  function automatic void model_reset();
    m_waiting = 0; m_masked = 0; m_timeout = 0; m_waited = 0;
  endfunction

  function automatic void model_step(input stim_t s);
    bit mw, redir, lu;
    mw = s.req && !s.rdy;
    redir = s.br || s.jmp;
    lu = s.memread && s.rd_idex != 0 && (s.rd_idex == s.rs1_id || s.rd_idex == s.rs2_id) && !m_masked;
    if (m_waiting && mw) begin
      if (m_waited < T) begin
        m_waited++;
        if (m_waited == T) m_timeout = 1;
      end
    end else begin
      m_waited = 0;
    end
    m_masked = !mw && !redir && lu;
    m_waiting = mw;
  endfunction

  task automatic applyStimulus(input stim_t s);
    rs1_id = s.rs1_id; rs2_id = s.rs2_id; rs1_idex = s.rs1_idex; rs2_idex = s.rs2_idex;
    rd_idex = s.rd_idex; memread_idex = s.memread;
    rd_exmem = s.rd_exmem; regwrite_exmem = s.rw_exmem;
    rd_memwb = s.rd_memwb; regwrite_memwb = s.rw_memwb;
    branch_taken_ex = s.br; jump_ex = s.jmp; dmem_req = s.req; dmem_ready = s.rdy;
  endtask

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b expected %b (pc,ifw,iff,idf,hold,fa,fb,st,to)", name, act, exp);
    end
  endtask

  function automatic logic [11:0] dut_out();
    return {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, fwd_a, fwd_b, ctrl_state, mem_timeout};
  endfunction

  // One clock cycle: drive at the falling edge, compare mid-cycle, advance the model on the rising edge.
  task automatic cycle(input stim_t s, input string name, input bit use_hand, input logic [11:0] hand);
    applyStimulus(s);
    #1;
    checkOutput({name, "/model"}, dut_out(), model_out(s));
    if (use_hand) checkOutput({name, "/table"}, dut_out(), hand);
    @(posedge clk);
    model_step(s);
    @(negedge clk);
  endtask

  vec_t  vecs[11];
  stim_t idle, mwj, rdyj, mwo, rdyo, s;

  initial begin
    idle = st(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
    vecs[0]  = '{idle, 12'b11000_00_00_00_0};
    vecs[1]  = '{st(0,0,0,0,7,0,7,1,7,1,0,0,0,0), 12'b11000_10_00_00_0};
    vecs[2]  = '{st(0,0,0,0,0,3,0,0,3,1,0,0,0,0), 12'b11000_00_01_00_0};
    vecs[3]  = '{st(0,0,0,0,0,0,0,1,0,1,0,0,0,0), 12'b11000_00_00_00_0};
    vecs[4]  = '{st(0,5,5,1,0,0,0,0,0,0,0,0,0,0), 12'b00010_00_00_00_0};
    vecs[5]  = '{st(0,5,5,1,0,0,0,0,0,0,0,0,0,0), 12'b11000_00_00_01_0};
    vecs[6]  = '{idle, 12'b11000_00_00_00_0};
    vecs[7]  = '{st(0,5,5,1,0,0,0,0,0,0,1,0,0,0), 12'b11110_00_00_00_0};
    vecs[8]  = '{idle, 12'b11000_00_00_00_0};
    vecs[9]  = '{st(0,0,0,1,0,0,0,0,0,0,0,0,0,0), 12'b11000_00_00_00_0};
    vecs[10] = '{st(0,0,0,0,0,9,9,1,9,1,0,0,0,0), 12'b11000_00_10_00_0};
    mwj  = st(0,0,0,0,0,0,0,0,0,0,0,1,1,0);
    rdyj = st(0,0,0,0,0,0,0,0,0,0,0,1,1,1);
    mwo  = st(0,0,0,0,0,0,0,0,0,0,0,0,1,0);
    rdyo = st(0,0,0,0,0,0,0,0,0,0,0,0,1,1);

    model_reset();
    applyStimulus(st(0,0,0,0,7,7,7,1,7,1,0,0,0,0));
    #1;
    checkOutput("reset_outputs", dut_out(), 12'b00110_00_00_00_0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) cycle(vecs[i].s, $sformatf("vec%0d", i), 1'b1, vecs[i].exp);

    // Memory wait with a jump pending: hold for three cycles, flush on the ready cycle.
    cycle(mwj,  "mw_jump_c1", 1'b1, 12'b00001_00_00_00_0);
    cycle(mwj,  "mw_jump_c2", 1'b1, 12'b00001_00_00_10_0);
    cycle(mwj,  "mw_jump_c3", 1'b1, 12'b00001_00_00_10_0);
    cycle(rdyj, "mw_jump_rdy", 1'b1, 12'b11110_00_00_10_0);
    cycle(idle, "mw_jump_after", 1'b1, 12'b11000_00_00_00_0);

    // Watchdog: flag appears after the fourth stayed MEM_WAIT cycle and is sticky.
    cycle(mwo, "wd_enter", 1'b1, 12'b00001_00_00_00_0);
    for (int i = 1; i <= T; i++) cycle(mwo, $sformatf("wd_wait%0d", i), 1'b1, 12'b00001_00_00_10_0);
    cycle(mwo,  "wd_flag",  1'b1, 12'b00001_00_00_10_1);
    cycle(rdyo, "wd_ready", 1'b1, 12'b11000_00_00_10_1);
    cycle(idle, "wd_sticky", 1'b1, 12'b11000_00_00_00_1);

    // Asynchronous reset in the middle of a memory wait.
    cycle(mwo, "rst_mw_enter", 1'b1, 12'b00001_00_00_00_1);
    applyStimulus(st(0,0,0,0,7,0,7,1,0,0,0,0,1,0));
    #1;
    checkOutput("rst_mw_before", dut_out(), 12'b00001_10_00_10_1);
    #1 rst = 1'b0;
    #1;
    checkOutput("rst_async", dut_out(), 12'b00110_00_00_00_0);
    @(posedge clk);
    model_reset();
    #1;
    checkOutput("rst_held", dut_out(), 12'b00110_00_00_00_0);
    @(negedge clk);
    rst = 1'b1;
    cycle(idle, "rst_release", 1'b1, 12'b11000_00_00_00_0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        applyStimulus(rand_stim());
        rst = 1'b0;
        #1;
        checkOutput("rand_reset", dut_out(), 12'b00110_00_00_00_0);
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
      end
      s = rand_stim();
      cycle(s, $sformatf("rand%0d", i), 1'b0, 12'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
